bit_stuff_sequencer: RTL and testbench

Sequencer for the receive-side bit-stuffing monitor in the CAN XL core. It tracks received bits from SOF and generates the run-length counters, fixed-stuff position counter and received-bit count that the monitor compares against the bus. It identifies each stuff bit so the destuffer can drop it. It also switches from dynamic to fixed stuffing when the protocol FSM signals the data-phase boundary, and it aborts the frame on a stuff error.

---
 rtl/bit_stuff_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_bit_stuff_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stuff_sequencer.sv
// Receive-side bit-stuffing sequencer for the CAN XL core.
// Tracks sampled bits from SOF, keeps the dynamic and fixed run-length
// counters, the fixed-stuff position counter and the received-bit count,
// flags stuff bits so the destuffer can drop them, and aborts the frame on
// a stuff error.
//
// Handshake: i_sample_en is a one-cycle strobe. i_serial_in, i_frame_start
// and i_fixed_stuff_en are only looked at when it is high. i_frame_end and
// i_stf_err act in any cycle while a frame is active. Every output is
// registered and updates at the edge that ends the strobe cycle. During a
// strobe cycle the counters therefore still describe the bits before the
// current sample.
module bit_stuff_sequencer #(
    parameter logic [4:0] FIX_STF_POS = 5'd15,
    parameter logic [2:0] RUN_LEN     = 3'd5
) (
    input  logic        i_clk,
    input  logic        i_g_rst,
    input  logic        i_sample_en,
    input  logic        i_serial_in,
    input  logic        i_frame_start,
    input  logic        i_fixed_stuff_en,
    input  logic        i_frame_end,
    input  logic        i_stf_err,
    output logic [2:0]  o_one_count,
    output logic [2:0]  o_zero_count,
    output logic [2:0]  o_one_count1,
    output logic [2:0]  o_zero_count1,
    output logic [4:0]  o_bit_count,
    output logic [14:0] o_rcvd_bt_cnt,
    output logic        o_stuff_bit,
    output logic        o_data_out,
    output logic        o_data_valid,
    output logic        o_stf_abort,
    output logic [1:0]  o_seq_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DYN  = 2'd1,
        ST_FIX  = 2'd2
    } seq_state_t;

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;

    logic [2:0]  r_one_count,  w_one_count;
    logic [2:0]  r_zero_count, w_zero_count;
    logic [2:0]  r_one_count1, w_one_count1;
    logic [2:0]  r_zero_count1, w_zero_count1;
    logic [4:0]  r_bit_count,  w_bit_count;
    logic [14:0] r_rcvd_bt_cnt, w_rcvd_bt_cnt;
    logic        r_stuff_bit,  w_stuff_bit;
    logic        r_data_out,   w_data_out;
    logic        r_data_valid, w_data_valid;
    logic        r_stf_abort,  w_stf_abort;

    logic        w_dyn_stuff;
    logic [14:0] w_rcvd_inc;

    // Run-length update shared by the dynamic and fixed counter pairs.
    // A bit that differs from the previous one (or a restart) sets its own
    // counter to 1; a repeated bit increments it, saturating at 7. The
    // opposite counter always goes to 0. Returns {ones, zeros}.
    function automatic logic [5:0] run_upd(input logic       bit_in,
                                           input logic [2:0] ones,
                                           input logic [2:0] zeros,
                                           input logic       restart);
        logic [2:0] n_one;
        logic [2:0] n_zero;
        n_one  = 3'd0;
        n_zero = 3'd0;
        if (bit_in) begin
            if (restart || ones == 3'd0) n_one = 3'd1;
            else if (ones == 3'd7)       n_one = 3'd7;
            else                         n_one = ones + 3'd1;
        end else begin
            if (restart || zeros == 3'd0) n_zero = 3'd1;
            else if (zeros == 3'd7)       n_zero = 3'd7;
            else                          n_zero = zeros + 3'd1;
        end
        return {n_one, n_zero};
    endfunction

    assign w_dyn_stuff = (r_one_count == RUN_LEN) || (r_zero_count == RUN_LEN);
    assign w_rcvd_inc  = (r_rcvd_bt_cnt == 15'h7FFF) ? 15'h7FFF : r_rcvd_bt_cnt + 15'd1;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_g_rst) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: stuff error and frame end win over the DYN->FIX switch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_sample_en && i_frame_start) w_state_nxt = ST_DYN;
            ST_DYN: begin
                if (i_stf_err || i_frame_end)              w_state_nxt = ST_IDLE;
                else if (i_sample_en && i_fixed_stuff_en) w_state_nxt = ST_FIX;
            end
            ST_FIX:  if (i_stf_err || i_frame_end) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of counters, data and pulses for this cycle.
    always_comb begin
        w_one_count   = r_one_count;
        w_zero_count  = r_zero_count;
        w_one_count1  = r_one_count1;
        w_zero_count1 = r_zero_count1;
        w_bit_count   = r_bit_count;
        w_rcvd_bt_cnt = r_rcvd_bt_cnt;
        w_data_out    = r_data_out;
        w_stuff_bit   = 1'b0;
        w_data_valid  = 1'b0;
        w_stf_abort   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // SOF is the first dynamic-region bit; counters start from 0.
                if (i_sample_en && i_frame_start) begin
                    {w_one_count, w_zero_count} = run_upd(i_serial_in, 3'd0, 3'd0, 1'b1);
                    w_rcvd_bt_cnt = 15'd1;
                    w_data_valid  = 1'b1;
                    w_data_out    = i_serial_in;
                end
            end
            ST_DYN, ST_FIX: begin
                if (i_stf_err || i_frame_end) begin
                    w_stf_abort   = i_stf_err;
                    w_one_count   = 3'd0;
                    w_zero_count  = 3'd0;
                    w_one_count1  = 3'd0;
                    w_zero_count1 = 3'd0;
                    w_bit_count   = 5'd0;
                    w_rcvd_bt_cnt = 15'd0;
                end else if (i_sample_en) begin
                    w_rcvd_bt_cnt = w_rcvd_inc;
                    if (r_state == ST_DYN && i_fixed_stuff_en) begin
                        // Switching sample: dynamic counters retire, fixed
                        // position count starts from 0.
                        w_one_count  = 3'd0;
                        w_zero_count = 3'd0;
                        w_bit_count  = 5'd0;
                        w_data_valid = 1'b1;
                        w_data_out   = i_serial_in;
                    end else if (r_state == ST_DYN) begin
                        {w_one_count, w_zero_count} =
                            run_upd(i_serial_in, r_one_count, r_zero_count, w_dyn_stuff);
                        if (w_dyn_stuff) begin
                            w_stuff_bit = 1'b1;
                        end else begin
                            w_data_valid = 1'b1;
                            w_data_out   = i_serial_in;
                        end
                    end else begin
                        // Fixed region: stuff bits still count toward the runs.
                        {w_one_count1, w_zero_count1} =
                            run_upd(i_serial_in, r_one_count1, r_zero_count1, 1'b0);
                        if (r_bit_count == FIX_STF_POS) begin
                            w_stuff_bit = 1'b1;
                            w_bit_count = 5'd0;
                        end else begin
                            w_bit_count  = r_bit_count + 5'd1;
                            w_data_valid = 1'b1;
                            w_data_out   = i_serial_in;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_g_rst) begin
            r_one_count   <= 3'd0;
            r_zero_count  <= 3'd0;
            r_one_count1  <= 3'd0;
            r_zero_count1 <= 3'd0;
            r_bit_count   <= 5'd0;
            r_rcvd_bt_cnt <= 15'd0;
            r_stuff_bit   <= 1'b0;
            r_data_out    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_stf_abort   <= 1'b0;
        end else begin
            r_one_count   <= w_one_count;
            r_zero_count  <= w_zero_count;
            r_one_count1  <= w_one_count1;
            r_zero_count1 <= w_zero_count1;
            r_bit_count   <= w_bit_count;
            r_rcvd_bt_cnt <= w_rcvd_bt_cnt;
            r_stuff_bit   <= w_stuff_bit;
            r_data_out    <= w_data_out;
            r_data_valid  <= w_data_valid;
            r_stf_abort   <= w_stf_abort;
        end
    end

    assign o_one_count   = r_one_count;
    assign o_zero_count  = r_zero_count;
    assign o_one_count1  = r_one_count1;
    assign o_zero_count1 = r_zero_count1;
    assign o_bit_count   = r_bit_count;
    assign o_rcvd_bt_cnt = r_rcvd_bt_cnt;
    assign o_stuff_bit   = r_stuff_bit;
    assign o_data_out    = r_data_out;
    assign o_data_valid  = r_data_valid;
    assign o_stf_abort   = r_stf_abort;
    assign o_seq_state   = r_state;

endmodule

// File: tb/tb_bit_stuff_sequencer.sv
// Directed bench for bit_stuff_sequencer.
module tb_bit_stuff_sequencer;

    logic        clk = 1'b0;
    logic        g_rst = 1'b0;
    logic        sample_en = 1'b0;
    logic        serial_in = 1'b0;
    logic        frame_start = 1'b0;
    logic        fixed_stuff_en = 1'b0;
    logic        frame_end = 1'b0;
    logic        stf_err = 1'b0;
    logic [2:0]  one_count, zero_count, one_count1, zero_count1;
    logic [4:0]  bit_count;
    logic [14:0] rcvd_bt_cnt;
    logic        stuff_bit, data_out, data_valid, stf_abort;
    logic [1:0]  seq_state;

    int n_chk  = 0;
    int n_pass = 0;

    bit_stuff_sequencer dut (
        .i_clk(clk), .i_g_rst(g_rst), .i_sample_en(sample_en), .i_serial_in(serial_in),
        .i_frame_start(frame_start), .i_fixed_stuff_en(fixed_stuff_en),
        .i_frame_end(frame_end), .i_stf_err(stf_err),
        .o_one_count(one_count), .o_zero_count(zero_count),
        .o_one_count1(one_count1), .o_zero_count1(zero_count1),
        .o_bit_count(bit_count), .o_rcvd_bt_cnt(rcvd_bt_cnt),
        .o_stuff_bit(stuff_bit), .o_data_out(data_out), .o_data_valid(data_valid),
        .o_stf_abort(stf_abort), .o_seq_state(seq_state)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus; outputs are settled when this returns.
    task automatic step(input logic en, input logic b, input logic sof,
                        input logic fx, input logic fe, input logic err);
        @(negedge clk);
        sample_en = en; serial_in = b; frame_start = sof;
        fixed_stuff_en = fx; frame_end = fe; stf_err = err;
        @(posedge clk); #1;
        sample_en = 1'b0; frame_start = 1'b0; fixed_stuff_en = 1'b0;
        frame_end = 1'b0; stf_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); g_rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); g_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({one_count, zero_count, one_count1, zero_count1, bit_count, rcvd_bt_cnt,
             stuff_bit, data_out, data_valid, stf_abort, seq_state} !== 39'd0)
            $display("FAIL reset_outputs: got %0h required 0",
                     {one_count, zero_count, one_count1, zero_count1, bit_count, rcvd_bt_cnt,
                      stuff_bit, data_out, data_valid, stf_abort, seq_state});
        else n_pass++;
    endtask

    task automatic test_dyn_stuff();
        do_reset();
        step(1, 0, 1, 0, 0, 0);  // SOF
        n_chk++;
        if ({seq_state, one_count, zero_count, rcvd_bt_cnt, data_valid, data_out}
            !== {2'd1, 3'd0, 3'd1, 15'd1, 1'b1, 1'b0})
            $display("FAIL dyn_sof: state=%0d one=%0d zero=%0d rcvd=%0d dv=%0b dout=%0b required 1 0 1 1 1 0",
                     seq_state, one_count, zero_count, rcvd_bt_cnt, data_valid, data_out);
        else n_pass++;
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
        n_chk++;
        if ({one_count, zero_count, stuff_bit} !== {3'd5, 3'd0, 1'b0})
            $display("FAIL dyn_run5: one=%0d zero=%0d stuff=%0b required 5 0 0",
                     one_count, zero_count, stuff_bit);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0);  // stuff bit
        n_chk++;
        if ({stuff_bit, data_valid, one_count, zero_count} !== {1'b1, 1'b0, 3'd0, 3'd1})
            $display("FAIL dyn_stuff: stuff=%0b dv=%0b one=%0d zero=%0d required 1 0 0 1",
                     stuff_bit, data_valid, one_count, zero_count);
        else n_pass++;
        step(1, 1, 0, 0, 0, 0);
        n_chk++;
        if ({stuff_bit, data_valid, data_out, one_count, zero_count, rcvd_bt_cnt}
            !== {1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 15'd8})
            $display("FAIL dyn_after: stuff=%0b dv=%0b dout=%0b one=%0d zero=%0d rcvd=%0d required 0 1 1 1 0 8",
                     stuff_bit, data_valid, data_out, one_count, zero_count, rcvd_bt_cnt);
        else n_pass++;
    endtask

    // SOF(0) then eight 0s: stuff decision fires after the fifth zero run.
    task automatic test_malformed_zeros();
        logic [2:0] exp_z [8];
        logic       exp_s [8];
        exp_z = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_chk++;
            if ({zero_count, one_count, stuff_bit} !== {exp_z[i], 3'd0, exp_s[i]})
                $display("FAIL zeros_%0d: zero=%0d one=%0d stuff=%0b required %0d 0 %0b",
                         i, zero_count, one_count, stuff_bit, exp_z[i], exp_s[i]);
            else n_pass++;
        end
        step(0, 0, 0, 0, 0, 1);  // stuff error
        n_chk++;
        if ({stf_abort, seq_state, zero_count, rcvd_bt_cnt} !== {1'b1, 2'd0, 3'd0, 15'd0})
            $display("FAIL zeros_abort: abort=%0b state=%0d zero=%0d rcvd=%0d required 1 0 0 0",
                     stf_abort, seq_state, zero_count, rcvd_bt_cnt);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0);
        n_chk++;
        if ({stf_abort, seq_state} !== {1'b0, 2'd0})
            $display("FAIL zeros_abort_pulse: abort=%0b state=%0d required 0 0", stf_abort, seq_state);
        else n_pass++;
    endtask

    task automatic test_fixed();
        do_reset();
        step(1, 1, 1, 0, 0, 0);  // SOF
        for (int i = 0; i < 9; i++) step(1, i[0] ? 1'b1 : 1'b0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);  // switching sample
        n_chk++;
        if ({seq_state, one_count, zero_count, bit_count} !== {2'd2, 3'd0, 3'd0, 5'd0})
            $display("FAIL fix_entry: state=%0d one=%0d zero=%0d bc=%0d required 2 0 0 0",
                     seq_state, one_count, zero_count, bit_count);
        else n_pass++;
        for (int i = 1; i <= 15; i++) begin
            step(1, 1, 0, 1, 0, 0);
            n_chk++;
            if ({bit_count, one_count, zero_count, data_valid, stuff_bit}
                !== {i[4:0], 3'd0, 3'd0, 1'b1, 1'b0})
                $display("FAIL fix_count_%0d: bc=%0d one=%0d zero=%0d dv=%0b stuff=%0b required %0d 0 0 1 0",
                         i, bit_count, one_count, zero_count, data_valid, stuff_bit, i);
            else n_pass++;
        end
        n_chk++;
        if ({one_count1, zero_count1} !== {3'd7, 3'd0})
            $display("FAIL fix_run_sat: one1=%0d zero1=%0d required 7 0", one_count1, zero_count1);
        else n_pass++;
        step(1, 0, 0, 1, 0, 0);  // 16th FIX sample
        n_chk++;
        if ({stuff_bit, data_valid, bit_count, rcvd_bt_cnt, one_count1, zero_count1}
            !== {1'b1, 1'b0, 5'd0, 15'd27, 3'd0, 3'd1})
            $display("FAIL fix_stuff: stuff=%0b dv=%0b bc=%0d rcvd=%0d one1=%0d zero1=%0d required 1 0 0 27 0 1",
                     stuff_bit, data_valid, bit_count, rcvd_bt_cnt, one_count1, zero_count1);
        else n_pass++;
    endtask

    // Continues from the FIX state left by test_fixed.
    task automatic test_end_and_err();
        step(0, 0, 0, 0, 1, 1);
        n_chk++;
        if ({stf_abort, seq_state, rcvd_bt_cnt, zero_count1, bit_count}
            !== {1'b1, 2'd0, 15'd0, 3'd0, 5'd0})
            $display("FAIL end_err: abort=%0b state=%0d rcvd=%0d zero1=%0d bc=%0d required 1 0 0 0 0",
                     stf_abort, seq_state, rcvd_bt_cnt, zero_count1, bit_count);
        else n_pass++;
        step(1, 1, 0, 0, 0, 0);  // no SOF: stays idle
        n_chk++;
        if ({stf_abort, seq_state, rcvd_bt_cnt, data_valid} !== {1'b0, 2'd0, 15'd0, 1'b0})
            $display("FAIL end_err_idle: abort=%0b state=%0d rcvd=%0d dv=%0b required 0 0 0 0",
                     stf_abort, seq_state, rcvd_bt_cnt, data_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fix();
        do_reset();
        step(1, 0, 1, 0, 0, 0);  // SOF
        step(1, 1, 1, 0, 0, 0);  // frame_start outside IDLE ignored
        n_chk++;
        if ({seq_state, rcvd_bt_cnt, one_count} !== {2'd1, 15'd2, 3'd1})
            $display("FAIL sof_in_dyn: state=%0d rcvd=%0d one=%0d required 1 2 1",
                     seq_state, rcvd_bt_cnt, one_count);
        else n_pass++;
        step(0, 0, 0, 1, 0, 0);  // no strobe: nothing changes
        n_chk++;
        if ({seq_state, rcvd_bt_cnt, one_count, zero_count} !== {2'd1, 15'd2, 3'd1, 3'd0})
            $display("FAIL no_strobe: state=%0d rcvd=%0d one=%0d zero=%0d required 1 2 1 0",
                     seq_state, rcvd_bt_cnt, one_count, zero_count);
        else n_pass++;
        step(1, 0, 0, 1, 0, 0);  // switch
        for (int i = 0; i < 9; i++) step(1, i[0] ? 1'b1 : 1'b0, 0, 0, 0, 0);
        n_chk++;
        if ({seq_state, bit_count, rcvd_bt_cnt} !== {2'd2, 5'd9, 15'd12})
            $display("FAIL pre_reset: state=%0d bc=%0d rcvd=%0d required 2 9 12",
                     seq_state, bit_count, rcvd_bt_cnt);
        else n_pass++;
        do_reset();
        n_chk++;
        if ({one_count, zero_count, one_count1, zero_count1, bit_count, rcvd_bt_cnt,
             stuff_bit, data_out, data_valid, stf_abort, seq_state} !== 39'd0)
            $display("FAIL mid_reset: got %0h required 0",
                     {one_count, zero_count, one_count1, zero_count1, bit_count, rcvd_bt_cnt,
                      stuff_bit, data_out, data_valid, stf_abort, seq_state});
        else n_pass++;
        step(1, 1, 1, 0, 0, 0);
        n_chk++;
        if ({seq_state, rcvd_bt_cnt, one_count} !== {2'd1, 15'd1, 3'd1})
            $display("FAIL restart: state=%0d rcvd=%0d one=%0d required 1 1 1",
                     seq_state, rcvd_bt_cnt, one_count);
        else n_pass++;
    endtask

    task automatic test_rcvd_saturation();
        do_reset();
        step(1, 0, 1, 0, 0, 0);  // SOF -> 1
        step(1, 1, 0, 1, 0, 0);  // switch -> 2
        for (int i = 0; i < 32764; i++) step(1, i[0] ? 1'b1 : 1'b0, 0, 0, 0, 0);
        n_chk++;
        if (rcvd_bt_cnt !== 15'd32766)
            $display("FAIL rcvd_near: rcvd=%0d required 32766", rcvd_bt_cnt);
        else n_pass++;
        step(1, 1, 0, 0, 0, 0);
        n_chk++;
        if (rcvd_bt_cnt !== 15'd32767)
            $display("FAIL rcvd_max: rcvd=%0d required 32767", rcvd_bt_cnt);
        else n_pass++;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        n_chk++;
        if ({rcvd_bt_cnt, seq_state} !== {15'd32767, 2'd2})
            $display("FAIL rcvd_hold: rcvd=%0d state=%0d required 32767 2", rcvd_bt_cnt, seq_state);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dyn_stuff();
        test_malformed_zeros();
        test_fixed();
        test_end_and_err();
        test_reset_mid_fix();
        test_rcvd_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
